// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: start/busy/done handshake and ALU command bus for alu_mul_seq; master = datapath+ALU side, slave = multiplier
interface alu_mul_seq_if #(
  parameter int WIDTH = 64,
  parameter int OPW = 32
);
  logic start;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [WIDTH-1:0] alu_out;
  logic alu_equal;
  modport master (
    output start, op_a, op_b, alu_out, alu_equal,
    input busy, done, product, alu_a, alu_b, alu_ctrl
  );
  modport slave (
    input start, op_a, op_b, alu_out, alu_equal,
    output busy, done, product, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier commanding an external ALU; ports clk, rst, bus (start/op_a/op_b/alu_out/alu_equal in, busy/done/product/alu_a/alu_b/alu_ctrl out)
module alu_mul_seq #(
  parameter int WIDTH = 64,
  parameter int OPW = 32
) (
  input logic clk,
  input logic rst,
  alu_mul_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TEST, ADD, SHL, SHR, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] acc, mcand, mplier, product, alu_a, alu_b;
  logic [2:0] alu_ctrl;
  logic [5:0] iter;
  always_comb begin
    state_n = state;
    alu_a = '0;
    alu_b = '0;
    alu_ctrl = 3'b000;
    case (state)
      IDLE: state_n = bus.start ? TEST : IDLE;
      TEST: begin
        alu_a = mplier;
        state_n = (bus.alu_equal || iter == 6'(OPW)) ? DONE : mplier[0] ? ADD : SHL;
      end
      ADD: begin
        alu_a = acc;
        alu_b = mcand;
        state_n = SHL;
      end
      SHL: begin
        alu_a = mcand;
        alu_ctrl = 3'b100;
        state_n = SHR;
      end
      SHR: begin
        alu_a = mplier;
        alu_ctrl = 3'b101;
        state_n = TEST;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      product <= '0;
      iter <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (bus.start) begin
          acc <= '0;
          mcand <= WIDTH'(bus.op_a);
          mplier <= WIDTH'(bus.op_b);
          iter <= '0;
        end
        TEST: if (state_n == DONE) product <= acc;
        ADD: acc <= bus.alu_out;
        SHL: mcand <= bus.alu_out;
        SHR: begin
          mplier <= bus.alu_out;
          iter <= iter + 6'd1;
        end
        default: ;
      endcase
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.product = product;
  assign bus.alu_a = alu_a;
  assign bus.alu_b = alu_b;
  assign bus.alu_ctrl = alu_ctrl;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: table, hand-written and random checks of alu_mul_seq against an arithmetic model with a behavioural ALU
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_mul_seq_if #(.WIDTH(64), .OPW(32)) bus();
  alu_mul_seq #(.WIDTH(64), .OPW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always_comb begin
    bus.alu_out = bus.alu_ctrl == 3'b000 ? bus.alu_a + bus.alu_b :
                  bus.alu_ctrl == 3'b100 ? bus.alu_a << 1 :
                  bus.alu_ctrl == 3'b101 ? bus.alu_a >> 1 : 64'd0;
    bus.alu_equal = bus.alu_a == bus.alu_b;
  end
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int inj;
    int lat;
    logic [63:0] prod;
  } vec_t;
  vec_t tbl[5];
  int tests = 0;
  int fails = 0;
  logic [2:0] ctrl_q[$];
  logic [63:0] a_q[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int lat_model(input logic [31:0] b);
    int n = 2;
    for (int i = 0; i < 32; i++) if ((b >> i) != 0) n += 3 + int'(b[i]);
    return n;
  endfunction
  // Called just after a negedge; leaves the bench just after the negedge of the IDLE cycle following done.
  task automatic check_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                           input int inj, input int exp_lat, input logic [63:0] exp_prod);
    int lat = 0;
    logic busy_ok = 1'b1;
    logic [63:0] prod = 64'd0;
    ctrl_q.delete();
    a_q.delete();
    bus.start = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 300 && lat == 0; k++) begin
      @(negedge clk);
      busy_ok &= bus.busy;
      if (bus.done) begin
        lat = k;
        prod = bus.product;
      end else begin
        ctrl_q.push_back(bus.alu_ctrl);
        a_q.push_back(bus.alu_a);
      end
      bus.start = k == inj;
      bus.op_a = $urandom;
      bus.op_b = $urandom;
    end
    bus.start = 1'b1;
    @(negedge clk);
    chk($sformatf("%s latency", name), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s product", name), prod, exp_prod);
    chk($sformatf("%s busy", name), 64'(busy_ok), 64'd1);
    chk($sformatf("%s idle after done", name), {62'd0, bus.busy, bus.done}, 64'd0);
    chk($sformatf("%s product held", name), bus.product, exp_prod);
    bus.start = 1'b0;
  endtask
  initial begin
    logic [2:0] exp_c[5];
    logic [63:0] exp_a[5];
    logic [31:0] ra, rb;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    tbl[0] = '{32'd3, 32'd5, 0, 13, 64'd15};
    tbl[1] = '{32'hDEADBEEF, 32'd0, 0, 2, 64'd0};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 130, 64'hFFFFFFFE00000001};
    tbl[3] = '{32'd7, 32'd1, 0, 6, 64'd7};
    tbl[4] = '{32'd3, 32'd5, 3, 13, 64'd15};
    exp_c = '{3'b000, 3'b000, 3'b100, 3'b101, 3'b000};
    exp_a = '{64'd1, 64'd0, 64'd7, 64'd1, 64'd0};
    repeat (2) @(negedge clk);
    chk("reset busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("reset product", bus.product, 64'd0);
    chk("reset alu", bus.alu_a | bus.alu_b | 64'(bus.alu_ctrl), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++)
      check_mul($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].inj, tbl[i].lat, tbl[i].prod);
    check_mul("zero mplier seq", 32'hDEADBEEF, 32'd0, 0, 2, 64'd0);
    chk("zero mplier ctrl count", 64'(ctrl_q.size()), 64'd1);
    if (ctrl_q.size() > 0) chk("zero mplier ctrl", 64'(ctrl_q[0]), 64'd0);
    check_mul("one mplier seq", 32'd7, 32'd1, 0, 6, 64'd7);
    chk("one mplier ctrl count", 64'(ctrl_q.size()), 64'd5);
    for (int i = 0; i < 5 && i < ctrl_q.size(); i++) begin
      chk($sformatf("one mplier ctrl%0d", i), 64'(ctrl_q[i]), 64'(exp_c[i]));
      chk($sformatf("one mplier alu_a%0d", i), a_q[i], exp_a[i]);
    end
    bus.start = 1'b1;
    bus.op_a = 32'hFFFFFFFF;
    bus.op_b = 32'hFFFFFFFF;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("abort product", bus.product, 64'd0);
    chk("abort alu", bus.alu_a | bus.alu_b | 64'(bus.alu_ctrl), 64'd0);
    rst = 1'b0;
    check_mul("after abort", 32'd2, 32'd3, 0, 10, 64'd6);
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      check_mul($sformatf("rand%0d", i), ra, rb, $urandom_range(0, 8), lat_model(rb), 64'(ra) * 64'(rb));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
